// File: rtl/seg7_display_scheduler.sv
// Round-robin / manual selector of four 32-bit debug words for the 8-digit hex display.
// Optional leading-zero blanking is built when SEG7_SCHED_BLANK_EN is defined.
module seg7_display_scheduler #(
  parameter logic [31:0] DWELL_CYCLES = 32'd50_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] sourceData,
  input  logic [3:0]   sourceValid,
  input  logic         autoMode,
  input  logic         stepPulse,
  input  logic         holdDisplay,
  output logic [31:0]  displayData32,
  output logic [1:0]   sourceIndex,
  output logic         updateStrobe,
  output logic [7:0]   blankMask
);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        strobe_q, strobe_d;
  logic        auto_q;
  logic [1:0]  nxt, low, j;
  logic        found, adv;

  // Current index is scanned last, so it only reselects itself when alone.
  always_comb begin
    nxt   = idx_q;
    low   = '0;
    found = 1'b0;
    j     = '0;
    for (int o = 1; o <= 4; o++) begin
      j = idx_q + 2'(o);
      if (!found && sourceValid[j]) begin
        nxt   = j;
        found = 1'b1;
      end
    end
    for (int i = 3; i >= 0; i--)
      if (sourceValid[i]) low = 2'(i);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        data_d = '0;
        if (|sourceValid) begin
          state_d  = SHOW;
          idx_d    = low;
          strobe_d = 1'b1;
          data_d   = sourceData[{low, 5'd0} +: 32];
        end
      end
      SHOW: begin
        if (sourceValid == 4'd0) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else begin
          if (!sourceValid[idx_q]) begin
            adv   = 1'b1;
            cnt_d = '0;
          end else if (!holdDisplay) begin
            if (!autoMode) begin
              cnt_d = '0;
              adv   = stepPulse;
            end else if (autoMode != auto_q) begin
              cnt_d = '0;
            end else if (cnt_q == DWELL_CYCLES - 32'd1) begin
              adv   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          if (adv) begin
            idx_d    = nxt;
            strobe_d = (nxt != idx_q);
          end
          if (adv || !holdDisplay)
            data_d = sourceData[{idx_d, 5'd0} +: 32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      auto_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      auto_q   <= autoMode;
    end
  end

  assign displayData32 = data_q;
  assign sourceIndex   = idx_q;
  assign updateStrobe  = strobe_q;

`ifdef SEG7_SCHED_BLANK_EN
  logic [7:0] blank_q, blank_d;

  // Digit 0 always shows, so a zero word still displays "0".
  always_comb begin
    blank_d = '0;
    for (int k = 1; k < 8; k++)
      blank_d[k] = ((data_d >> (4 * k)) == 32'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end

  assign blankMask = blank_q;
`else
  assign blankMask = 8'h00;
`endif

endmodule
